sc_sng_array: RTL
=================

# sc_sng_array

Multi-channel stochastic number generator for the stochastic-computing datapath. One shared maximal-length LFSR is compared against N_CH binary operands, each through its own XOR decorrelation mask and programmable delay. The result is N_CH bitstreams of length 2^W−1, produced under a start/done handshake. Each channel also counts the ones in its stream, which closes the stochastic-to-binary loop for self-check and downstream conversion. The block replaces hand-generated fixed 8-bit LFSR/comparator/flip-flop front ends in generated circuits.

## Interface
- W, 8, LFSR, operand and count width; stream length L = 2^W−1
- N_CH, 4, number of channels
- DELAY_MAX, 4, maximum per-channel stream delay in cycles (≥1); DW = $clog2(DELAY_MAX+1)
- TAPS, 8'h4D, LFSR feedback mask; must give a maximal-length sequence
- SEED, 8'h01, LFSR load value; must be nonzero
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  start request, sampled only in IDLE
- value_in  in  N_CH*W  operand per channel (channel c at [c*W +: W])
- inv_mask  in  N_CH*W  XOR mask applied to the LFSR state per channel
- delay_sel  in  N_CH*DW  stream delay per channel
- busy  out  1  high while a run is in progress
- stream_out  out  N_CH  registered stochastic bits
- stream_valid  out  1  stream_out carries a sample
- done  out  1  one-cycle pulse marking the end of the run
- count_out  out  N_CH*W  ones count per channel; valid from done until the next accepted start

## Operation
- **LFSR:** shifts right. New MSB = ^(state & TAPS); all other bits take state[i+1]. It visits every nonzero W-bit value once per L steps.
- **FSM:** IDLE → RUN → DRAIN → IDLE.
- **IDLE, start=1:**
  - latch value_in, inv_mask and delay_sel
  - load LFSR with SEED
  - clear delay lines and counters
  - go to RUN
- **RUN:** lasts exactly L cycles. Each cycle:
  - comparator bit_c = ((lfsr ^ mask_c) < value_c), unsigned, W bits
  - the bit is registered into delay line c
  - stream_valid <= 1
  - LFSR steps
  - After the L-th cycle, go to DRAIN.
- **DRAIN:** one cycle. Set stream_valid <= 0 and done <= 1, then go to IDLE.
- **Delay line:** the comparator register is stage 0, followed by DELAY_MAX further stages.
  - stream_out_c = stage[delay_sel_c].
  - delay_sel_c > DELAY_MAX clamps to DELAY_MAX.
  - Delayed channels emit 0 for their first delay_sel_c samples; the last delay_sel_c bits are dropped.
- **Counters:** on every edge with stream_valid=1, count_c += stream_out_c. W bits is sufficient and cannot overflow.
- **Exact result for delay 0:** count_c = value_c − (mask_c < value_c ? 1 : 0), because r^mask covers every W-bit value except mask.
- **start while busy or done:** ignored. The latched configuration is stable for the whole run.
- **rst_n=0 at any time:** applies the reset values below; an aborted run produces no done.

## Timing
- **Reset values:**
  - busy, stream_out, stream_valid, done and count_out = 0
  - FSM in IDLE
  - LFSR = SEED
- Let E0 be the edge at which start is accepted. busy rises after E0.
- stream_valid is high after edges E1..EL (L cycles) and low after E(L+1).
- done is high for the single cycle after E(L+1), with count_out final. busy is low in that cycle.
- Start-to-done latency is L+1 edges (256 for W=8). The next start can be accepted in the done cycle.
- All outputs are registered; there is no combinational input-to-output path.

## Structure
- **Package sc_pkg:**
  - default TAPS/SEED constants for W=8
  - function lfsr_next(state, taps)
  - FSM state enum {IDLE, RUN, DRAIN}
- **Sub-module sc_lfsr** (W, TAPS, SEED; ports load, en, state).
- The channel comparator, delay line and counter are a generate loop in the top module.

## Test plan
- **Operand sweep.** Setup: W=8, value={0,1,128,255}, masks 0, delays 0. Response: counts {0,0,127,254}; done exactly 256 edges after start; stream_valid high for 255 cycles.
- **Mask decorrelation.** Setup: value=128 with mask 0x80, and value=128 with mask 0x01. Response: counts 128 and 127; the two streams differ bit-for-bit versus the mask-0 stream.
- **Delay.** Setup: ch0 and ch1 both value=100, mask 0, delays 0 and 3. Response: stream_out[1](t) = stream_out[0](t−3); the first 3 ch1 samples are 0. Also, delay_sel=7 with DELAY_MAX=4 behaves as 4.
- **Handshake.** Stimulus: pulse start mid-run with new values. Response: ignored and the original counts are delivered. Stimulus: start in the done cycle. Response: accepted, fresh run.
- **Mid-run reset.** Stimulus: rst_n=0 for one cycle at sample 100. Response: all outputs 0 and no done. Stimulus: the following start. Response: reproduces the sweep counts exactly.

Source files
------------

// File: rtl/sc_pkg.sv
// Shared types and helpers for the stochastic number generator array.
package sc_pkg;

  localparam int unsigned SC_W = 8;
  localparam logic [SC_W-1:0] SC_TAPS = 8'h4D;
  localparam logic [SC_W-1:0] SC_SEED = 8'h01;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } sc_state_e;

  // Right-shifting Fibonacci step: new MSB is the parity of the tapped bits.
  function automatic logic [31:0] lfsr_next(input logic [31:0] state,
                                            input logic [31:0] taps,
                                            input int unsigned w);
    logic [31:0] mask;
    logic        fb;
    mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    fb   = ^(state & taps & mask);
    return ((state & mask) >> 1) | ({31'd0, fb} << (w - 1));
  endfunction

endpackage

// File: rtl/sc_sng_array_if.sv
// Control, configuration and result bus of the SNG array.
interface sc_sng_array_if #(
  parameter int unsigned W    = 8,
  parameter int unsigned N_CH = 4,
  parameter int unsigned DW   = 3
);
  logic                 start;
  logic [N_CH*W-1:0]    value_in;
  logic [N_CH*W-1:0]    inv_mask;
  logic [N_CH*DW-1:0]   delay_sel;
  logic                 busy;
  logic [N_CH-1:0]      stream_out;
  logic                 stream_valid;
  logic                 done;
  logic [N_CH*W-1:0]    count_out;

  modport master (
    output start, value_in, inv_mask, delay_sel,
    input  busy, stream_out, stream_valid, done, count_out
  );

  modport slave (
    input  start, value_in, inv_mask, delay_sel,
    output busy, stream_out, stream_valid, done, count_out
  );
endinterface

// File: rtl/sc_lfsr.sv
// Shared maximal-length LFSR; reloads SEED on load, steps on en.
module sc_lfsr
  import sc_pkg::*;
#(
  parameter int unsigned    W    = SC_W,
  parameter logic [W-1:0]   TAPS = W'(SC_TAPS),
  parameter logic [W-1:0]   SEED = W'(SC_SEED)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  output logic [W-1:0] state
);

  // State register: seed on reset/load, one step per enabled cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= SEED;
    end else if (load) begin
      state <= SEED;
    end else if (en) begin
      state <= W'(lfsr_next(32'(state), 32'(TAPS), W));
    end
  end

endmodule

// File: rtl/sc_sng_array.sv
// Multi-channel stochastic number generator with per-channel mask, delay and ones counter.
module sc_sng_array
  import sc_pkg::*;
#(
  parameter int unsigned  W         = SC_W,
  parameter int unsigned  N_CH      = 4,
  parameter int unsigned  DELAY_MAX = 4,
  parameter logic [W-1:0] TAPS      = W'(SC_TAPS),
  parameter logic [W-1:0] SEED      = W'(SC_SEED)
) (
  input  logic          clk,
  input  logic          rst_n,
  sc_sng_array_if.slave bus
);

  localparam int unsigned  DW       = $clog2(DELAY_MAX + 1);
  // Last run-counter value: L-1 = 2^W-2.
  localparam logic [W-1:0] RUN_LAST = {{(W-1){1'b1}}, 1'b0};

  sc_state_e    state_q, state_d;
  logic         accept_c, run_c, drain_c;
  logic [W-1:0] run_cnt_q;
  logic         busy_q, valid_q, done_q;
  logic [W-1:0] lfsr;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and control strobes.
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    run_c    = 1'b0;
    drain_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          accept_c = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        run_c = 1'b1;
        if (run_cnt_q == RUN_LAST) state_d = DRAIN;
      end
      DRAIN: begin
        drain_c = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Run length counter and registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_cnt_q <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept_c) begin
        run_cnt_q <= '0;
        busy_q    <= 1'b1;
      end
      if (run_c) begin
        run_cnt_q <= run_cnt_q + W'(1);
        valid_q   <= 1'b1;
      end
      if (drain_c) begin
        valid_q <= 1'b0;
        done_q  <= 1'b1;
        busy_q  <= 1'b0;
      end
    end
  end

  sc_lfsr #(.W(W), .TAPS(TAPS), .SEED(SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept_c),
    .en    (run_c),
    .state (lfsr)
  );

  assign bus.busy         = busy_q;
  assign bus.stream_valid = valid_q;
  assign bus.done         = done_q;

  for (genvar c = 0; c < int'(N_CH); c++) begin : g_ch
    logic [W-1:0]         val_q, mask_q, cnt_q;
    logic [DW-1:0]        sel_q, sel_in;
    logic [DELAY_MAX-1:0] sh_q;
    logic                 out_q, cmp_c, tap_c;

    assign sel_in = bus.delay_sel[c*DW +: DW];
    assign cmp_c  = (lfsr ^ mask_q) < val_q;

    // Select the delay tap; the output register itself acts as the selected stage.
    always_comb begin
      tap_c = cmp_c;
      for (int k = 0; k < int'(DELAY_MAX); k++) begin
        if (sel_q == DW'(k + 1)) tap_c = sh_q[k];
      end
    end

    // Configuration latch, delay line, output bit and ones counter.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        val_q  <= '0;
        mask_q <= '0;
        sel_q  <= '0;
        sh_q   <= '0;
        out_q  <= 1'b0;
        cnt_q  <= '0;
      end else if (accept_c) begin
        val_q  <= bus.value_in[c*W +: W];
        mask_q <= bus.inv_mask[c*W +: W];
        sel_q  <= (sel_in > DW'(DELAY_MAX)) ? DW'(DELAY_MAX) : sel_in;
        sh_q   <= '0;
        out_q  <= 1'b0;
        cnt_q  <= '0;
      end else begin
        if (run_c) begin
          sh_q  <= DELAY_MAX'({sh_q, cmp_c});
          out_q <= tap_c;
        end
        if (drain_c) out_q <= 1'b0;
        if (valid_q) cnt_q <= cnt_q + W'(out_q);
      end
    end

    assign bus.stream_out[c]        = out_q;
    assign bus.count_out[c*W +: W]  = cnt_q;
  end

endmodule
